// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream
// Description : Streaming KxK 2-D convolution with line buffers, shift/clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int K          = 3,
    parameter int MAX_WIDTH  = 256,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_we,
    input  logic [4:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int c_NCOEF = K * K;
    localparam int c_AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int c_ID    = (K % 2 == 1) ? (K / 2) * K + K / 2 : 0;
    localparam logic signed [ACC_WIDTH-1:0] c_PIX_MAX =
        {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_width, r_height, r_col, r_row;
    logic [4:0]            r_shift;
    logic [COEF_WIDTH-1:0] r_coef [c_NCOEF];
    logic                  r_busy, r_done, r_err, r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] r_lb   [K-1][MAX_WIDTH];
    logic [DATA_WIDTH-1:0] r_win  [K][K];

    logic                         w_accept, w_emit, w_start_ok;
    logic [c_AW-1:0]              w_addr;
    logic [DATA_WIDTH-1:0]        w_col [K];
    logic [DATA_WIDTH-1:0]        w_win [K][K];
    logic signed [ACC_WIDTH-1:0]  w_acc, w_shifted;
    logic [DATA_WIDTH-1:0]        w_result;
    logic                         w_unused_bits;

    assign w_unused_bits = &{1'b0, cfg_wdata[31:16]};

    assign in_ready   = (r_state == c_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_emit     = w_accept && (r_row >= 16'(K-1)) && (r_col >= 16'(K-1));
    assign w_start_ok = (r_width >= 16'(K)) && (32'(r_width) <= 32'(MAX_WIDTH))
                        && (r_height >= 16'(K));
    assign w_addr     = r_col[c_AW-1:0];

    // Window as it will look once the incoming column is shifted in, so the
    // result can be registered on the accepting edge.
    always_comb begin
        w_col[K-1] = in_data;
        for (int k = 0; k < K-1; k++)
            w_col[K-2-k] = r_lb[k][w_addr];
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++)
                w_win[i][j] = r_win[i][j+1];
            w_win[i][K-1] = w_col[i];
        end
        w_acc = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w_acc = w_acc
                    + $signed({{(ACC_WIDTH-COEF_WIDTH){r_coef[i*K+j][COEF_WIDTH-1]}}, r_coef[i*K+j]})
                    * $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_win[i][j]});
        w_shifted = w_acc >>> r_shift;
        if (w_shifted[ACC_WIDTH-1])
            w_result = '0;
        else if (w_shifted > c_PIX_MAX)
            w_result = {DATA_WIDTH{1'b1}};
        else
            w_result = w_shifted[DATA_WIDTH-1:0];
    end

    // Line buffers and window carry no reset; the row/column counters gate results.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb[0][w_addr] <= in_data;
            for (int k = 1; k < K-1; k++)
                r_lb[k][w_addr] <= r_lb[k-1][w_addr];
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    r_win[i][j] <= w_win[i][j];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_shift     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int n = 0; n < c_NCOEF; n++)
                r_coef[n] <= (n == c_ID) ? COEF_WIDTH'(1) : '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (cfg_we && !r_busy) begin
                case (cfg_addr)
                    5'd0:    r_width  <= cfg_wdata[15:0];
                    5'd1:    r_height <= cfg_wdata[15:0];
                    5'd2:    r_shift  <= cfg_wdata[4:0];
                    default: ;
                endcase
                for (int n = 0; n < c_NCOEF; n++)
                    if (cfg_addr == 5'(n + 3))
                        r_coef[n] <= cfg_wdata[COEF_WIDTH-1:0];
            end

            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_state <= c_RUN;
                            r_busy  <= 1'b1;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (w_accept) begin
                        if (r_col == r_width - 16'd1) begin
                            r_col <= '0;
                            if (r_row == r_height - 16'd1)
                                r_state <= c_FLUSH;
                            else
                                r_row <= r_row + 16'd1;
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                    end
                end
                c_FLUSH: begin
                    if (!r_out_valid || out_ready) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv2d_stream
// Description : Scoreboard bench for conv2d_stream (K=3, 8-bit pixels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv2d_stream;

    localparam int c_DW = 8;
    localparam int c_CW = 8;
    localparam int c_K  = 3;
    localparam int c_MW = 256;
    localparam int c_AW = 24;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cfg_we = 1'b0;
    logic [4:0]       cfg_addr = '0;
    logic [31:0]      cfg_wdata = '0;
    logic             start = 1'b0;
    logic [c_DW-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [c_DW-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             busy, done, err;

    conv2d_stream #(
        .DATA_WIDTH (c_DW),
        .COEF_WIDTH (c_CW),
        .K          (c_K),
        .MAX_WIDTH  (c_MW),
        .ACC_WIDTH  (c_AW)
    ) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int q_exp[$];
    int cf[c_K*c_K];
    int sh;
    int pix[64];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: every handshaken result is popped against the model.
    always @(negedge clk) begin
        if (resetn) begin
            if (done) n_done++;
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0)
                    check("unexpected_out", 1, 0);
                else
                    check("out_data", int'(out_data), q_exp.pop_front());
            end
        end
    end

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = 5'(addr);
        cfg_wdata = 32'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_coefs(input int v);
        for (int n = 0; n < c_K*c_K; n++) begin
            cf[n] = v;
            cfg_write(n + 3, v);
        end
    endtask

    task automatic model_push(input int w, input int h);
        int acc;
        for (int r = c_K-1; r < h; r++)
            for (int c = c_K-1; c < w; c++) begin
                acc = 0;
                for (int i = 0; i < c_K; i++)
                    for (int j = 0; j < c_K; j++)
                        acc += cf[i*c_K+j] * pix[(r-c_K+1+i)*w + (c-c_K+1+j)];
                acc = acc >>> sh;
                if (acc < 0) acc = 0;
                if (acc > 255) acc = 255;
                q_exp.push_back(acc);
            end
    endtask

    task automatic do_stall();
        int held;
        out_ready = 1'b0;
        @(posedge clk); #1;
        held = int'(out_data);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_valid", int'(out_valid), 1);
            check("stall_hold", int'(out_data), held);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic send(input int n, input int stall_at);
        bit got;
        for (int p = 0; p < n; p++) begin
            in_data  = c_DW'(pix[p]);
            in_valid = 1'b1;
            if (p == stall_at) do_stall();
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            if (!got) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic begin_frame(input int w, input int h);
        cfg_write(0, w);
        cfg_write(1, h);
        cfg_write(2, sh);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_frame(input int w, input int h, input int stall_at);
        int d0;
        bit seen;
        model_push(w, h);
        begin_frame(w, h);
        d0 = n_done;
        send(w * h, stall_at);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(posedge clk); #1;
            if (n_done != d0) seen = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", n_done - d0, 1);
        check("busy_after_done", int'(busy), 0);
        check("queue_empty", q_exp.size(), 0);
        q_exp.delete();
    endtask

    task automatic fill(input int n, input int v);
        for (int p = 0; p < n; p++) pix[p] = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Identity from reset-time coefficients, 4x4 ramp -> 5,6,9,10
        for (int n = 0; n < c_K*c_K; n++) cf[n] = (n == 4) ? 1 : 0;
        sh = 0;
        for (int p = 0; p < 16; p++) pix[p] = p;
        run_frame(4, 4, -1);

        // Box filter and clamping on 3x3 frames
        set_coefs(1);
        fill(9, 10);  run_frame(3, 3, -1);
        fill(9, 200); run_frame(3, 3, -1);
        set_coefs(-1);
        run_frame(3, 3, -1);

        // Shift
        set_coefs(1);
        sh = 3;
        fill(9, 8);   run_frame(3, 3, -1);

        // Backpressure mid-frame with random pixels and coefficients
        sh = 2;
        for (int n = 0; n < c_K*c_K; n++) begin
            cf[n] = $urandom_range(8) - 4;
            cfg_write(n + 3, cf[n]);
        end
        for (int p = 0; p < 20; p++) pix[p] = $urandom_range(255);
        run_frame(5, 4, 14);

        // Bad configuration: width below K
        cfg_write(0, 2);
        cfg_write(1, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_cfg_err", int'(err), 1);
        check("bad_cfg_busy", int'(busy), 0);
        @(posedge clk); #1;
        check("bad_cfg_err_pulse", int'(err), 0);
        for (int p = 0; p < 16; p++) pix[p] = 255 - p * 7;
        run_frame(4, 4, -1);

        // Reset in the middle of a frame, then a clean frame
        for (int p = 0; p < 16; p++) pix[p] = p;
        begin_frame(4, 4);
        send(7, -1);
        resetn = 1'b0;
        #2;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        q_exp.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int n = 0; n < c_K*c_K; n++) cf[n] = (n == 4) ? 1 : 0;
        sh = 0;
        run_frame(4, 4, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
